nbit_slt_seq: RTL and testbench

//  Parametrised, iterative set-less-than unit: the multi-cycle successor of the fixed 32-bit

---
 rtl/nbit_slt_seq.sv | 119 +++++++++++
 tb/tb_nbit_slt_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/nbit_slt_seq.sv
// rtl/nbit_slt_seq.sv - iterative signed/unsigned set-less-than, CHUNK bits per cycle, MSB chunk first
module nbit_slt_seq #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPARE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("nbit_slt_seq: WIDTH must be a multiple of CHUNK");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             decided_q, decided_d;
  logic             lt_acc_q, lt_acc_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;

  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic [WIDTH-1:0] msb_flip;
  logic             differ, decided_now, lt_now;

  assign chunk_a  = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign chunk_b  = b_q[int'(idx_q)*CHUNK +: CHUNK];
  assign differ   = (chunk_a != chunk_b);
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign msb_flip = {is_signed, {(WIDTH-1){1'b0}}};

  assign decided_now = decided_q | differ;
  assign lt_now      = decided_q ? lt_acc_q : (chunk_a < chunk_b);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    lt_acc_d  = lt_acc_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d       = a ^ msb_flip;
          b_d       = b ^ msb_flip;
          idx_d     = IDXW'(NCHUNK - 1);
          decided_d = 1'b0;
          lt_acc_d  = 1'b0;
          state_d   = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (differ && !decided_q) begin
          decided_d = 1'b1;
          lt_acc_d  = lt_now;
        end
        if ((EARLY_EXIT != 0 && differ) || idx_q == '0) begin
          state_d = S_DONE;
          lt_d    = decided_now & lt_now;
          eq_d    = ~decided_now;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      lt_acc_q  <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      lt_acc_q  <= lt_acc_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign out_valid = (state_q == S_DONE);
  assign lt        = lt_q;
  assign eq        = eq_q;

endmodule

// File: tb/tb_nbit_slt_seq.sv
// tb/tb_nbit_slt_seq.sv - scoreboard bench: dut0 32/8 early-exit, dut1 32/8 full scan, dut2 16/4 random
module tb_nbit_slt_seq;

  typedef struct {
    logic lt;
    logic eq;
    int   lat;
    int   acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  in_valid = '0;
  logic [2:0]  is_signed = '0;
  logic [2:0]  out_ready = 3'b111;
  logic [31:0] a_in [3];
  logic [31:0] b_in [3];
  wire  [2:0]  in_ready, out_valid, lt, eq;
  logic [2:0]  prev_v = '0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          t6_run = 1'b0;
  exp_t        sb [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nbit_slt_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) u_ee (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_in[0]), .b(b_in[0]), .is_signed(is_signed[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .lt(lt[0]), .eq(eq[0]));

  nbit_slt_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) u_full (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_in[1]), .b(b_in[1]), .is_signed(is_signed[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .lt(lt[1]), .eq(eq[1]));

  nbit_slt_seq #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1)) u_w16 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_in[2][15:0]), .b(b_in[2][15:0]), .is_signed(is_signed[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .lt(lt[2]), .eq(eq[2]));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Reference: plain integer comparison plus position of the first differing chunk.
  function automatic exp_t model(input int d, input logic [31:0] av, input logic [31:0] bv,
                                 input logic s, input int acc);
    exp_t   m;
    int     w, c;
    bit     found;
    longint mask, am, bm, sa, sbv;
    w    = (d == 2) ? 16 : 32;
    c    = (d == 2) ? 4 : 8;
    mask = (longint'(1) << w) - 1;
    am   = longint'(av) & mask;
    bm   = longint'(bv) & mask;
    sa   = (s && am[w-1]) ? am - (mask + 1) : am;
    sbv  = (s && bm[w-1]) ? bm - (mask + 1) : bm;
    m.lt  = (sa < sbv);
    m.eq  = (am == bm);
    m.lat = w / c;
    m.acc = acc;
    found = 1'b0;
    if (d != 1) begin
      for (int i = 1; i <= w / c; i++) begin
        if (!found && ((am >> (w - i * c)) != (bm >> (w - i * c)))) begin
          m.lat = i;
          found = 1'b1;
        end
      end
    end
    return m;
  endfunction

  task automatic send(input int d, input logic [31:0] av, input logic [31:0] bv, input logic s);
    int n;
    a_in[d]      = av;
    b_in[d]      = bv;
    is_signed[d] = s;
    in_valid[d]  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[d]) begin
      chk($sformatf("dut%0d_accept_timeout", d), 32'd0, 32'd1);
    end else begin
      sb[d].push_back(model(d, av, bv, s, cyc + 1));
    end
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!reset && out_valid[d]) begin
        if (sb[d].size() == 0) begin
          chk($sformatf("dut%0d_spurious_out_valid", d), 32'd1, 32'd0);
        end else begin
          if (!prev_v[d]) chk($sformatf("dut%0d_latency", d), cyc - sb[d][0].acc, sb[d][0].lat);
          chk($sformatf("dut%0d_lt", d), {31'd0, lt[d]}, {31'd0, sb[d][0].lt});
          chk($sformatf("dut%0d_eq", d), {31'd0, eq[d]}, {31'd0, sb[d][0].eq});
          if (out_ready[d]) void'(sb[d].pop_front());
        end
      end
      prev_v[d] <= out_valid[d] & !reset;
    end
  end

  initial begin
    int          n;
    int          mode;
    logic [31:0] ra, rb;
    for (int d = 0; d < 3; d++) begin
      a_in[d] = '0;
      b_in[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {29'd0, out_valid}, 32'd0);
    chk("reset_lt", {29'd0, lt}, 32'd0);
    chk("reset_eq", {29'd0, eq}, 32'd0);
    reset = 1'b0;
    #1 chk("post_reset_in_ready", {29'd0, in_ready}, 32'd7);

    send(0, 32'h11111111, 32'h99999999, 1'b0);
    send(0, 32'h11111111, 32'h99999999, 1'b1);
    send(0, 32'h99999999, 32'h11111111, 1'b1);
    send(0, 32'h11111111, 32'h11111111, 1'b0);
    send(0, 32'h11111111, 32'h11111111, 1'b1);
    send(1, 32'h11111111, 32'h99999999, 1'b0);
    send(1, 32'h11111111, 32'h11111111, 1'b1);
    send(1, 32'h00000080, 32'hFFFFFF00, 1'b1);

    out_ready[0] = 1'b0;
    send(0, 32'h12345600, 32'h12345601, 1'b0);
    fork
      send(0, 32'hFFFF0000, 32'h0000FFFF, 1'b1);
      begin
        n = 0;
        while (!out_valid[0] && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("t4_valid_seen", {31'd0, out_valid[0]}, 32'd1);
        repeat (5) begin
          @(negedge clk);
          chk("t4_stall_in_ready", {31'd0, in_ready[0]}, 32'd0);
          chk("t4_stall_out_valid", {31'd0, out_valid[0]}, 32'd1);
        end
        @(posedge clk);
        #1 out_ready[0] = 1'b1;
      end
    join

    send(0, 32'h00000001, 32'h00000002, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int d = 0; d < 3; d++) sb[d].delete();
    #1;
    chk("t5_reset_out_valid", {31'd0, out_valid[0]}, 32'd0);
    chk("t5_reset_lt", {31'd0, lt[0]}, 32'd0);
    chk("t5_reset_eq", {31'd0, eq[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("t5_in_ready_after_release", {31'd0, in_ready[0]}, 32'd1);
    send(0, 32'h80000000, 32'h7FFFFFFF, 1'b1);
    send(0, 32'h80000000, 32'h7FFFFFFF, 1'b0);

    t6_run = 1'b1;
    fork
      while (t6_run) begin
        @(posedge clk);
        #1 out_ready[2] = ($urandom % 3) != 0;
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          ra   = $urandom & 32'hFFFF;
          mode = $urandom % 4;
          if (mode == 0) rb = ra;
          else if (mode == 1) rb = ra ^ ((($urandom % 15) + 1) << (4 * ($urandom % 4)));
          else rb = $urandom & 32'hFFFF;
          send(2, ra, rb, 1'($urandom % 2));
        end
        t6_run = 1'b0;
      end
    join
    out_ready[2] = 1'b1;

    n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb[0].size() + sb[1].size() + sb[2].size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
